// File: rtl/demap_sched.sv
// demap_sched: frame sequencer around the shared symbol demapper, MSB-first byte packing
// and a small output byte FIFO. Optional statistics counters: define DEMAP_SCHED_STATS_EN.
module demap_sched #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [7:0]  cfg_hdr_syms,
    input  logic [15:0] cfg_pay_syms,
    input  logic [3:0]  cfg_pay_mod,
    input  logic [15:0] sym_re,
    input  logic [15:0] sym_im,
    input  logic        sym_valid,
    output logic        sym_ready,
    output logic [15:0] dm_sym_re,
    output logic [15:0] dm_sym_im,
    output logic        dm_sym_valid,
    output logic [3:0]  dm_mod_type,
    input  logic [7:0]  dm_bits,
    input  logic        dm_bits_valid,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        byte_last,
    output logic        byte_hdr,
    output logic        busy,
    output logic        frame_done,
    output logic        cfg_err
`ifdef DEMAP_SCHED_STATS_EN
    ,
    output logic [15:0] stat_frames,
    output logic [31:0] stat_syms
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, HDR, PAY, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [7:0]         hdr_rem_q, hdr_rem_d;
    logic [15:0]        pay_rem_q, pay_rem_d;
    logic [3:0]         pay_mod_q, pay_mod_d;
    logic               busy_q, cfg_err_q, cfg_err_d, frame_done_q, frame_done_d;
    logic [1:0]         inflight_q, inflight_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [9:0]         mem_q [FIFO_DEPTH];
    logic [15:0]        dm_re_q, dm_im_q;
    logic               dm_valid_q;
    logic [3:0]         dm_mod_q;
    logic               t1_hdr_q, t1_last_q, t1_hend_q, t1_wide_q;
    logic               t2_hdr_q, t2_last_q, t2_hend_q, t2_wide_q;
    logic [7:0]         acc_q, acc_d;
    logic [3:0]         acc_cnt_q, acc_cnt_d;

    logic               remaining_nz_s, room_s, sym_ready_s, sym_take_s;
    logic               pack_s, pack_wr_s, flush_s, wr_en_s, rd_en_s;
    logic [7:0]         bits_top_s, merged_s;
    logic [3:0]         new_cnt_s;
    logic [9:0]         wr_data_s;
    logic               unused_bits_s;

    assign unused_bits_s = ^dm_bits[7:4];

    // Input acceptance: space is reserved in the FIFO for every symbol still in flight.
    always_comb begin
        remaining_nz_s = 1'b0;
        if (state_q == HDR) begin
            remaining_nz_s = (hdr_rem_q != 8'd0);
        end else if (state_q == PAY) begin
            remaining_nz_s = (pay_rem_q != 16'd0);
        end else begin
            remaining_nz_s = 1'b0;
        end
        room_s      = (32'(fifo_cnt_q) + 32'(inflight_q)) < 32'(FIFO_DEPTH);
        sym_ready_s = remaining_nz_s && room_s;
        sym_take_s  = sym_valid && sym_ready_s;
        pack_s      = dm_bits_valid && (inflight_q != 2'd0);
        rd_en_s     = (fifo_cnt_q != {CNT_W{1'b0}}) && byte_ready;
    end

    // Frame sequencing FSM.
    always_comb begin
        state_d      = state_q;
        hdr_rem_d    = hdr_rem_q;
        pay_rem_d    = pay_rem_q;
        pay_mod_d    = pay_mod_q;
        cfg_err_d    = 1'b0;
        frame_done_d = 1'b0;
        flush_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    if ((cfg_pay_mod > 4'd1) || ((cfg_hdr_syms == 8'd0) && (cfg_pay_syms == 16'd0))) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        hdr_rem_d = cfg_hdr_syms;
                        pay_rem_d = cfg_pay_syms;
                        pay_mod_d = cfg_pay_mod;
                        state_d   = (cfg_hdr_syms != 8'd0) ? HDR : PAY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            HDR: begin
                if (sym_take_s) begin
                    hdr_rem_d = hdr_rem_q - 8'd1;
                    if (hdr_rem_q == 8'd1) begin
                        state_d = (pay_rem_q == 16'd0) ? DRAIN : PAY;
                    end else begin
                        state_d = HDR;
                    end
                end else begin
                    state_d = HDR;
                end
            end
            PAY: begin
                if (sym_take_s) begin
                    pay_rem_d = pay_rem_q - 16'd1;
                    if (pay_rem_q == 16'd1) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = PAY;
                    end
                end else begin
                    state_d = PAY;
                end
            end
            DRAIN: begin
                if (inflight_q == 2'd0) begin
                    if (acc_cnt_q != 4'd0) begin
                        flush_s = (fifo_cnt_q < CNT_W'(FIFO_DEPTH));
                    end else begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end
                end else begin
                    flush_s = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bit packing, FIFO write selection and occupancy bookkeeping.
    always_comb begin
        if (t2_wide_q) begin
            bits_top_s = {dm_bits[3:0], 4'h0};
        end else begin
            bits_top_s = {dm_bits[1:0], 6'h00};
        end
        merged_s  = acc_q | (bits_top_s >> acc_cnt_q);
        new_cnt_s = acc_cnt_q + (t2_wide_q ? 4'd4 : 4'd2);
        pack_wr_s = pack_s && ((new_cnt_s == 4'd8) || t2_hend_q);
        wr_en_s   = pack_wr_s || flush_s;
        if (pack_wr_s) begin
            wr_data_s = {t2_last_q, t2_hdr_q, merged_s};
        end else begin
            wr_data_s = {1'b1, 1'b0, acc_q};
        end
        if (wr_en_s) begin
            acc_d     = 8'h00;
            acc_cnt_d = 4'd0;
        end else if (pack_s) begin
            acc_d     = merged_s;
            acc_cnt_d = new_cnt_s;
        end else begin
            acc_d     = acc_q;
            acc_cnt_d = acc_cnt_q;
        end
        case ({sym_take_s, pack_s})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase
        case ({wr_en_s, rd_en_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // State, pipeline and FIFO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hdr_rem_q    <= 8'd0;
            pay_rem_q    <= 16'd0;
            pay_mod_q    <= 4'd0;
            busy_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
            inflight_q   <= 2'd0;
            fifo_cnt_q   <= {CNT_W{1'b0}};
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 10'h000;
            end
            dm_re_q      <= 16'h0000;
            dm_im_q      <= 16'h0000;
            dm_valid_q   <= 1'b0;
            dm_mod_q     <= 4'd0;
            {t1_hdr_q, t1_last_q, t1_hend_q, t1_wide_q} <= 4'b0000;
            {t2_hdr_q, t2_last_q, t2_hend_q, t2_wide_q} <= 4'b0000;
            acc_q        <= 8'h00;
            acc_cnt_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            hdr_rem_q    <= hdr_rem_d;
            pay_rem_q    <= pay_rem_d;
            pay_mod_q    <= pay_mod_d;
            busy_q       <= (state_d != IDLE);
            cfg_err_q    <= cfg_err_d;
            frame_done_q <= frame_done_d;
            inflight_q   <= inflight_d;
            fifo_cnt_q   <= fifo_cnt_d;
            dm_valid_q   <= sym_take_s;
            if (sym_take_s) begin
                dm_re_q   <= sym_re;
                dm_im_q   <= sym_im;
                dm_mod_q  <= (state_q == HDR) ? 4'd0 : pay_mod_q;
                t1_hdr_q  <= (state_q == HDR);
                t1_hend_q <= (state_q == HDR) && (hdr_rem_q == 8'd1);
                t1_last_q <= ((state_q == HDR) && (hdr_rem_q == 8'd1) && (pay_rem_q == 16'd0)) ||
                             ((state_q == PAY) && (pay_rem_q == 16'd1));
                t1_wide_q <= (state_q == PAY) && (pay_mod_q == 4'd1);
            end else begin
                dm_re_q   <= dm_re_q;
                dm_im_q   <= dm_im_q;
                dm_mod_q  <= dm_mod_q;
                {t1_hdr_q, t1_last_q, t1_hend_q, t1_wide_q} <= {t1_hdr_q, t1_last_q, t1_hend_q, t1_wide_q};
            end
            // The demapper has a fixed one-cycle latency, so tags follow one stage behind.
            {t2_hdr_q, t2_last_q, t2_hend_q, t2_wide_q} <= {t1_hdr_q, t1_last_q, t1_hend_q, t1_wide_q};
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= wr_data_s;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (rd_en_s) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
        end
    end

`ifdef DEMAP_SCHED_STATS_EN
    logic [15:0] stat_frames_q;
    logic [31:0] stat_syms_q;

    // Wrapping frame and symbol counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames_q <= 16'd0;
            stat_syms_q   <= 32'd0;
        end else begin
            stat_frames_q <= stat_frames_q + (frame_done_d ? 16'd1 : 16'd0);
            stat_syms_q   <= stat_syms_q + (sym_take_s ? 32'd1 : 32'd0);
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_syms   = stat_syms_q;
`endif

    assign sym_ready    = sym_ready_s;
    assign dm_sym_re    = dm_re_q;
    assign dm_sym_im    = dm_im_q;
    assign dm_sym_valid = dm_valid_q;
    assign dm_mod_type  = dm_mod_q;
    assign byte_out     = mem_q[rd_ptr_q][7:0];
    assign byte_hdr     = (fifo_cnt_q != {CNT_W{1'b0}}) && mem_q[rd_ptr_q][8];
    assign byte_last    = (fifo_cnt_q != {CNT_W{1'b0}}) && mem_q[rd_ptr_q][9];
    assign byte_valid   = (fifo_cnt_q != {CNT_W{1'b0}});
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_demap_sched.sv
// Bench for demap_sched: demapper model, per-frame byte scoreboard, table of frames plus
// hand sequences for backpressure stall, ignored frame_start and mid-frame reset.
module tb_demap_sched;

    logic        clk = 1'b0, rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [7:0]  cfg_hdr_syms = 8'd0;
    logic [15:0] cfg_pay_syms = 16'd0;
    logic [3:0]  cfg_pay_mod = 4'd0;
    logic [15:0] sym_re = 16'd0, sym_im = 16'd0;
    logic        sym_valid = 1'b0, sym_ready;
    logic [15:0] dm_sym_re, dm_sym_im;
    logic        dm_sym_valid;
    logic [3:0]  dm_mod_type;
    logic [7:0]  dm_bits;
    logic        dm_bits_valid;
    logic [7:0]  byte_out;
    logic        byte_valid, byte_ready = 1'b0, byte_last, byte_hdr;
    logic        busy, frame_done, cfg_err;
`ifdef DEMAP_SCHED_STATS_EN
    logic [15:0] stat_frames;
    logic [31:0] stat_syms;
`endif

    demap_sched #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .cfg_hdr_syms(cfg_hdr_syms), .cfg_pay_syms(cfg_pay_syms), .cfg_pay_mod(cfg_pay_mod),
        .sym_re(sym_re), .sym_im(sym_im), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .dm_sym_re(dm_sym_re), .dm_sym_im(dm_sym_im), .dm_sym_valid(dm_sym_valid),
        .dm_mod_type(dm_mod_type), .dm_bits(dm_bits), .dm_bits_valid(dm_bits_valid),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_last(byte_last), .byte_hdr(byte_hdr),
        .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
`ifdef DEMAP_SCHED_STATS_EN
        ,
        .stat_frames(stat_frames), .stat_syms(stat_syms)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int hdr; int pay; int mod; int pat; int rdy;
        bit exp_err; int exp_nbytes;
    } frame_t;

    int checks = 0, passes = 0, fails = 0;
    int fd_cnt = 0, ce_cnt = 0, dv_cnt = 0, nbytes = 0, acc_count = 0;
    int rdy_mode = 0;
    logic [9:0] sb[$];
    logic [9:0] log_q[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Reference demapper: upper bits are deliberately non-zero so unused bits must be ignored.
    function automatic logic [7:0] demap(input logic signed [15:0] re, input logic signed [15:0] im,
                                         input logic [3:0] mt);
        logic [1:0] ar, ai;
        if (mt == 4'd1) begin
            ar = {re >= 0, (re >= 0) ^ ((re > -16'sd16384) && (re < 16'sd16384))};
            ai = {im >= 0, (im >= 0) ^ ((im > -16'sd16384) && (im < 16'sd16384))};
            return {4'b1011, ar, ai};
        end else begin
            return {6'b110101, im < 0, (re < 0) ^ (im < 0)};
        end
    endfunction

    // External demapper model with its fixed one-cycle latency.
    always @(posedge clk) begin
        if (rst) begin
            dm_bits_valid <= 1'b0;
            dm_bits       <= 8'h00;
        end else begin
            dm_bits_valid <= dm_sym_valid;
            dm_bits       <= demap(dm_sym_re, dm_sym_im, dm_mod_type);
        end
    end

    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            0:       byte_ready = 1'b1;
            1:       byte_ready = 1'($urandom_range(0, 1));
            default: byte_ready = 1'b0;
        endcase
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (frame_done) fd_cnt++;
            if (cfg_err) ce_cnt++;
            if (dm_sym_valid) dv_cnt++;
            if (byte_valid && byte_ready) begin
                logic [9:0] got;
                got = {byte_last, byte_hdr, byte_out};
                chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) chk("byte", 32'(got), 32'(sb.pop_front()));
                log_q.push_back(got);
                nbytes++;
            end
        end
    end

    task automatic send_sym(input logic [15:0] re, input logic [15:0] im);
        int t = 0;
        bit a;
        sym_valid = 1'b1; sym_re = re; sym_im = im;
        do begin
            @(negedge clk); a = sym_ready;
            @(posedge clk); #1; t++;
        end while (!a && t < 500);
        chk("sym_accept_timeout", 32'(a), 32'd1);
        acc_count++;
        sym_valid = 1'b0;
    endtask

    task automatic run_frame(input frame_t f);
        logic signed [15:0] sre[$], sim[$];
        bit bq[$];
        int hbytes, nb, fd0, ce0, dv0, nb0, t;
        logic [7:0] m, bv;
        for (int i = 0; i < f.hdr + f.pay; i++) begin
            int k;
            k = (i < f.hdr) ? (i % 4) : ((i - f.hdr) % 4);
            if (i < f.hdr || f.pat == 0) begin
                sre.push_back((k == 0 || k == 3) ? 16'sd1000 : -16'sd1000);
                sim.push_back((k < 2) ? 16'sd1000 : -16'sd1000);
            end else if (f.pat == 1) begin
                sre.push_back((k % 2 == 0) ? 16'sd30000 : -16'sd30000);
                sim.push_back((k % 2 == 0) ? -16'sd10000 : 16'sd10000);
            end else begin
                sre.push_back(16'($urandom));
                sim.push_back(16'($urandom));
            end
        end
        if (!f.exp_err) begin
            for (int i = 0; i < f.hdr; i++) begin
                m = demap(sre[i], sim[i], 4'd0);
                bq.push_back(m[1]); bq.push_back(m[0]);
            end
            while (bq.size() % 8 != 0) bq.push_back(1'b0);
            hbytes = bq.size() / 8;
            for (int i = f.hdr; i < f.hdr + f.pay; i++) begin
                m = demap(sre[i], sim[i], 4'(f.mod));
                if (f.mod == 1) begin bq.push_back(m[3]); bq.push_back(m[2]); end
                bq.push_back(m[1]); bq.push_back(m[0]);
            end
            while (bq.size() % 8 != 0) bq.push_back(1'b0);
            nb = bq.size() / 8;
            for (int b = 0; b < nb; b++) begin
                for (int j = 0; j < 8; j++) bv[7 - j] = bq[b * 8 + j];
                sb.push_back({b == nb - 1, b < hbytes, bv});
            end
        end
        fd0 = fd_cnt; ce0 = ce_cnt; dv0 = dv_cnt; nb0 = nbytes; acc_count = 0;
        rdy_mode = (f.rdy == 2) ? 2 : f.rdy;
        @(posedge clk); #1;
        cfg_hdr_syms = 8'(f.hdr); cfg_pay_syms = 16'(f.pay); cfg_pay_mod = 4'(f.mod);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        if (f.exp_err) begin
            repeat (6) @(posedge clk);
            #1;
            chk("cfg_err_pulses", 32'(ce_cnt - ce0), 32'd1);
            chk("err_busy", 32'(busy), 32'd0);
            chk("err_no_dm_valid", 32'(dv_cnt - dv0), 32'd0);
            chk("err_no_done", 32'(fd_cnt - fd0), 32'd0);
        end else begin
            chk("busy_set", 32'(busy), 32'd1);
            for (int i = 0; i < f.hdr + f.pay; i++) send_sym(sre[i], sim[i]);
            t = 0;
            while (!((fd_cnt > fd0) && (sb.size() == 0)) && t < 3000) begin
                @(posedge clk); t++;
            end
            #1;
            chk("frame_timeout", 32'(t < 3000), 32'd1);
            chk("nbytes", 32'(nbytes - nb0), 32'(f.exp_nbytes));
            chk("frame_done_once", 32'(fd_cnt - fd0), 32'd1);
            chk("no_cfg_err", 32'(ce_cnt - ce0), 32'd0);
            chk("busy_clear", 32'(busy), 32'd0);
        end
    endtask

    frame_t tab[10];
    frame_t fx;

    initial begin
        int nl;
        tab[0] = '{4, 4, 0, 0, 0, 1'b0, 2};
        tab[1] = '{2, 2, 1, 1, 0, 1'b0, 2};
        tab[2] = '{3, 5, 1, 2, 1, 1'b0, 4};
        tab[3] = '{5, 0, 0, 2, 1, 1'b0, 2};
        tab[4] = '{0, 7, 0, 2, 0, 1'b0, 2};
        tab[5] = '{1, 1, 1, 2, 1, 1'b0, 2};
        tab[6] = '{0, 0, 0, 0, 0, 1'b1, 0};
        tab[7] = '{4, 4, 3, 0, 0, 1'b1, 0};
        tab[8] = '{8, 16, 1, 2, 1, 1'b0, 10};
        tab[9] = '{0, 1, 1, 2, 0, 1'b0, 1};

        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        chk("reset_outs", 32'({byte_out, byte_valid, byte_last, byte_hdr, dm_sym_valid, dm_mod_type,
                              busy, frame_done, cfg_err, sym_ready}), 32'd0);
        chk("reset_dm_sym", {dm_sym_re, dm_sym_im}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            nl = log_q.size();
            run_frame(tab[i]);
            if (i == 0 && log_q.size() >= nl + 2) begin
                chk("tp1_hdr_byte", 32'(log_q[nl]), 32'h11B);
                chk("tp1_pay_byte", 32'(log_q[nl + 1]), 32'h21B);
            end
            if (i == 1 && log_q.size() >= nl + 2) begin
                chk("tp2_hdr_byte", 32'(log_q[nl]), 32'h110);
                chk("tp2_pay_byte", 32'(log_q[nl + 1]), 32'h2D2);
            end
        end

        // frame_start with an illegal cfg during PAY must be ignored
        fx = '{0, 16, 0, 0, 0, 1'b0, 4};
        fork
            run_frame(fx);
            begin
                repeat (6) @(posedge clk);
                #1;
                cfg_hdr_syms = 8'd1; cfg_pay_syms = 16'd0; cfg_pay_mod = 4'd3;
                frame_start = 1'b1;
                @(posedge clk); #1;
                frame_start = 1'b0;
            end
        join

        // Consumer stalled through a 40-symbol QPSK payload
        fx = '{0, 40, 0, 0, 2, 1'b0, 10};
        fork
            run_frame(fx);
            begin
                int t = 0;
                while (acc_count < 16 && t < 500) begin @(posedge clk); t++; end
                repeat (20) @(posedge clk);
                @(negedge clk);
                chk("stall_accepted", 32'(acc_count), 32'd16);
                chk("stall_sym_ready", 32'(sym_ready), 32'd0);
                chk("stall_byte_valid", 32'(byte_valid), 32'd1);
                rdy_mode = 0;
            end
        join

        // Reset in the middle of a payload
        rdy_mode = 2;
        @(posedge clk); #1;
        cfg_hdr_syms = 8'd0; cfg_pay_syms = 16'd20; cfg_pay_mod = 4'd1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        for (int i = 0; i < 6; i++) send_sym(16'($urandom), 16'($urandom));
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_bytes", 32'(byte_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_outs", 32'({byte_out, byte_valid, byte_last, byte_hdr, dm_sym_valid, dm_mod_type,
                               busy, frame_done, cfg_err, sym_ready}), 32'd0);
        chk("midrst_dm_sym", {dm_sym_re, dm_sym_im}, 32'd0);
        rst = 1'b0;
        sb.delete();
`ifdef DEMAP_SCHED_STATS_EN
        chk("stat_frames_rst", 32'(stat_frames), 32'd0);
        chk("stat_syms_rst", stat_syms, 32'd0);
`endif
        run_frame(tab[0]);
`ifdef DEMAP_SCHED_STATS_EN
        chk("stat_frames", 32'(stat_frames), 32'd1);
        chk("stat_syms", stat_syms, 32'd8);
`endif
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
